// File: rtl/a2d_scan_if.sv
// Bus between the A2D scan sequencer, its requester and the downstream SPI master.
// The master modport is the sequencer's own view; slave is the surrounding system.
interface a2d_scan_if;
    logic        strt;
    logic [7:0]  chnl_mask;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic        busy;
    logic        res_wr;
    logic [2:0]  res_chnl;
    logic [11:0] res;
    logic        scan_done;
    logic        err;

    modport master (
        input  strt, chnl_mask, done, rd_data,
        output wrt, cmd, busy, res_wr, res_chnl, res, scan_done, err
    );

    modport slave (
        output strt, chnl_mask, done, rd_data,
        input  wrt, cmd, busy, res_wr, res_chnl, res, scan_done, err
    );
endinterface

// File: rtl/a2d_scan.sv
// Scans the enabled A2D channels in ascending order, issuing two SPI transactions per
// channel (the first primes the converter, the second returns its result).
module a2d_scan #(
    parameter int unsigned TMO_CYC = 2047
) (
    input  logic       clk,
    input  logic       rst,
    a2d_scan_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, SEL, CMD1, WAIT1, CMD2, WAIT2, STORE, FIN
    } state_t;

    localparam logic [11:0] TMO_LAST = 12'(TMO_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  pend_q, pend_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  chnl_q, chnl_d;
    logic [11:0] tmo_q, tmo_d;
    logic [11:0] res_q, res_d;
    logic [2:0]  res_chnl_q, res_chnl_d;
    logic [15:0] cmd_q, cmd_d;
    logic        wrt_q, wrt_d;
    logic        busy_q, busy_d;
    logic        res_wr_q, res_wr_d;
    logic        scan_done_q, scan_done_d;
    logic        err_q, err_d;

    logic        sel_found;
    logic [2:0]  sel_chnl;
    logic        rd_unused;

    // The converter only returns 12 significant bits.
    assign rd_unused = ^bus.rd_data[15:12];

    // Lowest pending channel at or above idx; scanning downward leaves the lowest hit.
    always_comb begin
        sel_found = 1'b0;
        sel_chnl  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_q[i] && (4'(i) >= idx_q)) begin
                sel_found = 1'b1;
                sel_chnl  = 3'(i);
            end
        end
    end

    // Strobes are registered from the next state so each one lines up with its state.
    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        pend_d      = pend_q;
        idx_d       = idx_q;
        chnl_d      = chnl_q;
        tmo_d       = tmo_q;
        res_d       = res_q;
        res_chnl_d  = res_chnl_q;
        cmd_d       = cmd_q;
        wrt_d       = 1'b0;
        res_wr_d    = 1'b0;
        scan_done_d = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.strt) begin
                    pend_d  = bus.chnl_mask;
                    idx_d   = 4'd0;
                    state_d = SEL;
                end
            end
            SEL: begin
                if (sel_found) begin
                    chnl_d           = sel_chnl;
                    pend_d[sel_chnl] = 1'b0;
                    cmd_d            = {2'b00, sel_chnl, 11'h000};
                    wrt_d            = 1'b1;
                    state_d          = CMD1;
                end else begin
                    scan_done_d = 1'b1;
                    state_d     = FIN;
                end
            end
            CMD1: begin
                tmo_d   = 12'd0;
                state_d = WAIT1;
            end
            WAIT1: begin
                if (bus.done) begin
                    wrt_d   = 1'b1;
                    state_d = CMD2;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    pend_d  = 8'h00;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 12'd1;
                end
            end
            CMD2: begin
                tmo_d   = 12'd0;
                state_d = WAIT2;
            end
            WAIT2: begin
                if (bus.done) begin
                    res_d      = bus.rd_data[11:0];
                    res_chnl_d = chnl_q;
                    res_wr_d   = 1'b1;
                    state_d    = STORE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    pend_d  = 8'h00;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 12'd1;
                end
            end
            STORE: begin
                idx_d   = {1'b0, chnl_q} + 4'd1;
                state_d = SEL;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= 8'h00;
            idx_q       <= 4'd0;
            chnl_q      <= 3'd0;
            tmo_q       <= 12'd0;
            res_q       <= 12'd0;
            res_chnl_q  <= 3'd0;
            cmd_q       <= 16'h0000;
            wrt_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_wr_q    <= 1'b0;
            scan_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            idx_q       <= idx_d;
            chnl_q      <= chnl_d;
            tmo_q       <= tmo_d;
            res_q       <= res_d;
            res_chnl_q  <= res_chnl_d;
            cmd_q       <= cmd_d;
            wrt_q       <= wrt_d;
            busy_q      <= busy_d;
            res_wr_q    <= res_wr_d;
            scan_done_q <= scan_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.wrt       = wrt_q;
    assign bus.cmd       = cmd_q;
    assign bus.busy      = busy_q;
    assign bus.res_wr    = res_wr_q;
    assign bus.res_chnl  = res_chnl_q;
    assign bus.res       = res_q;
    assign bus.scan_done = scan_done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_a2d_scan.sv
// Directed bench for a2d_scan: an SPI responder model on the main instance and a
// short-timeout instance driven by hand for abort and deadline-edge scenarios.
module tb_a2d_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    a2d_scan_if bus ();
    a2d_scan_if bus_t ();

    a2d_scan dut (.clk(clk), .rst(rst), .bus(bus.master));
    a2d_scan #(.TMO_CYC(16)) dut_t (.clk(clk), .rst(rst), .bus(bus_t.master));

    int n_vec = 0;
    int n_bad = 0;

    logic [11:0] res_tbl [8];

    // SPI responder: done arrives spi_delay cycles after each wrt; the first word of a
    // channel is junk, the second carries {4'hF, res_tbl[channel]}.
    int   spi_delay = 1;
    logic spi_en    = 1'b0;
    logic model_clr = 1'b1;
    int   spi_cnt   = 0;
    bit   spi_phase = 1'b0;

    always @(negedge clk) begin
        bus.done = 1'b0;
        if (model_clr) begin
            spi_cnt     = 0;
            spi_phase   = 1'b0;
            bus.rd_data = 16'h0000;
        end else begin
            if (spi_cnt > 0) begin
                spi_cnt--;
                if (spi_cnt == 0) begin
                    bus.done    = 1'b1;
                    bus.rd_data = spi_phase ? {4'hF, res_tbl[bus.cmd[13:11]]} : 16'hE0E0;
                    spi_phase   = ~spi_phase;
                end
            end
            if (bus.wrt && spi_en) spi_cnt = spi_delay;
        end
    end

    // Event monitor for the main instance.
    int          cyc = 0;
    logic        mon_clr = 1'b1;
    int          n_wrt, n_res, n_sd, n_err, n_busy, sd_cyc;
    logic [15:0] wrt_cmd [16];
    int          wrt_cyc [16];
    logic [2:0]  res_ch  [8];
    logic [11:0] res_v   [8];

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            n_wrt = 0; n_res = 0; n_sd = 0; n_err = 0; n_busy = 0; sd_cyc = 0;
        end else begin
            if (bus.wrt) begin
                if (n_wrt < 16) begin wrt_cmd[n_wrt] = bus.cmd; wrt_cyc[n_wrt] = cyc; end
                n_wrt++;
            end
            if (bus.res_wr) begin
                if (n_res < 8) begin res_ch[n_res] = bus.res_chnl; res_v[n_res] = bus.res; end
                n_res++;
            end
            if (bus.scan_done) begin sd_cyc = cyc; n_sd++; end
            if (bus.err) n_err++;
            if (bus.busy) n_busy++;
        end
    end

    task automatic clear_all();
        @(posedge clk); #1 mon_clr = 1'b1; model_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0; model_clr = 1'b0;
    endtask

    task automatic start(input logic [7:0] mask, output int ref_cyc);
        @(posedge clk); #1 bus.strt = 1'b1; bus.chnl_mask = mask; ref_cyc = cyc;
        @(posedge clk); #1 bus.strt = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (n_sd != 0 || n_err != 0) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_vec++; if ({bus.wrt, bus.busy, bus.res_wr, bus.scan_done, bus.err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 00000",
                              {bus.wrt, bus.busy, bus.res_wr, bus.scan_done, bus.err}); end
        n_vec++; if ({bus.cmd, bus.res, bus.res_chnl} !== 31'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", {bus.cmd, bus.res, bus.res_chnl}); end
        n_vec++; if ({bus_t.wrt, bus_t.busy, bus_t.err, bus_t.cmd} !== 19'h0) begin
            n_bad++; $display("FAIL reset_tmo_inst: got %h want 0",
                              {bus_t.wrt, bus_t.busy, bus_t.err, bus_t.cmd}); end
    endtask

    task automatic test_single();
        int r; bit to;
        spi_en = 1'b1; spi_delay = 40;
        clear_all();
        start(8'h01, r);
        wait_end(400, to);
        repeat (3) @(posedge clk); #1;
        n_vec++; if (to) begin n_bad++; $display("FAIL single_end: got timeout want scan_done"); end
        n_vec++; if (n_wrt !== 2) begin n_bad++; $display("FAIL single_wrt_cnt: got %0d want 2", n_wrt); end
        n_vec++; if (wrt_cmd[0] !== 16'h0000 || wrt_cmd[1] !== 16'h0000) begin
            n_bad++; $display("FAIL single_cmd: got %h/%h want 0000/0000", wrt_cmd[0], wrt_cmd[1]); end
        n_vec++; if (wrt_cyc[1] - wrt_cyc[0] !== 41) begin
            n_bad++; $display("FAIL single_wrt_gap: got %0d want 41", wrt_cyc[1] - wrt_cyc[0]); end
        n_vec++; if (n_res !== 1 || res_ch[0] !== 3'd0 || res_v[0] !== 12'hABC) begin
            n_bad++; $display("FAIL single_res: got n=%0d ch=%0d res=%h want n=1 ch=0 res=abc",
                              n_res, res_ch[0], res_v[0]); end
        n_vec++; if (n_sd !== 1 || n_err !== 0) begin
            n_bad++; $display("FAIL single_done: got sd=%0d err=%0d want sd=1 err=0", n_sd, n_err); end
        n_vec++; if (bus.res !== 12'hABC || bus.res_chnl !== 3'd0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL single_hold: got res=%h ch=%0d busy=%b want abc 0 0",
                              bus.res, bus.res_chnl, bus.busy); end
    endtask

    task automatic test_multi();
        int r; bit to;
        logic [2:0]  exp_ch  [3] = '{3'd2, 3'd5, 3'd7};
        logic [15:0] exp_cmd [3] = '{16'h1000, 16'h2800, 16'h3800};
        spi_en = 1'b1; spi_delay = 5;
        clear_all();
        start(8'hA4, r);
        wait_end(400, to);
        n_vec++; if (to) begin n_bad++; $display("FAIL multi_end: got timeout want scan_done"); end
        n_vec++; if (n_wrt !== 6) begin n_bad++; $display("FAIL multi_wrt_cnt: got %0d want 6", n_wrt); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (wrt_cmd[2*i] !== exp_cmd[i] || wrt_cmd[2*i+1] !== exp_cmd[i]) begin
                n_bad++; $display("FAIL multi_cmd%0d: got %h/%h want %h", i,
                                  wrt_cmd[2*i], wrt_cmd[2*i+1], exp_cmd[i]); end
            n_vec++; if (res_ch[i] !== exp_ch[i] || res_v[i] !== res_tbl[exp_ch[i]]) begin
                n_bad++; $display("FAIL multi_res%0d: got ch=%0d res=%h want ch=%0d res=%h", i,
                                  res_ch[i], res_v[i], exp_ch[i], res_tbl[exp_ch[i]]); end
        end
        n_vec++; if (n_res !== 3 || n_sd !== 1) begin
            n_bad++; $display("FAIL multi_counts: got res=%0d sd=%0d want 3 1", n_res, n_sd); end
    endtask

    task automatic test_empty();
        int r;
        clear_all();
        start(8'h00, r);
        repeat (8) @(posedge clk); #1;
        n_vec++; if (n_sd !== 1 || sd_cyc - (r + 1) !== 2) begin
            n_bad++; $display("FAIL empty_done: got n=%0d lat=%0d want n=1 lat=2", n_sd, sd_cyc - (r + 1)); end
        n_vec++; if (n_busy !== 2) begin n_bad++; $display("FAIL empty_busy: got %0d want 2", n_busy); end
        n_vec++; if (n_wrt !== 0 || n_res !== 0) begin
            n_bad++; $display("FAIL empty_quiet: got wrt=%0d res=%0d want 0 0", n_wrt, n_res); end
    endtask

    task automatic test_back_to_back();
        int r; bit to;
        spi_en = 1'b1; spi_delay = 1;
        clear_all();
        start(8'h21, r);
        bus.strt = 1'b1; bus.chnl_mask = 8'hFF;
        repeat (6) @(posedge clk);
        #1 bus.strt = 1'b0;
        wait_end(200, to);
        repeat (10) @(posedge clk); #1;
        n_vec++; if (to) begin n_bad++; $display("FAIL b2b_end: got timeout want scan_done"); end
        n_vec++; if (n_wrt !== 4 || n_res !== 2 || n_sd !== 1) begin
            n_bad++; $display("FAIL b2b_counts: got wrt=%0d res=%0d sd=%0d want 4 2 1", n_wrt, n_res, n_sd); end
        n_vec++; if (res_ch[0] !== 3'd0 || res_ch[1] !== 3'd5) begin
            n_bad++; $display("FAIL b2b_chnls: got %0d,%0d want 0,5", res_ch[0], res_ch[1]); end
        n_vec++; if (wrt_cyc[1] - wrt_cyc[0] !== 2) begin
            n_bad++; $display("FAIL b2b_min_gap: got %0d want 2", wrt_cyc[1] - wrt_cyc[0]); end
        n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int r; bit to;
        spi_en = 1'b1; spi_delay = 10;
        clear_all();
        start(8'hFF, r);
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (n_wrt >= 8) begin to = 1'b0; break; end
        end
        n_vec++; if (to) begin n_bad++; $display("FAIL rstmid_reach: got timeout want 8 wrt"); end
        #1;
        n_vec++; if (bus.res !== res_tbl[2]) begin
            n_bad++; $display("FAIL rstmid_pre_res: got %h want %h", bus.res, res_tbl[2]); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_vec++; if ({bus.wrt, bus.busy, bus.res_wr, bus.scan_done, bus.err,
                      bus.cmd, bus.res, bus.res_chnl} !== 36'h0) begin
            n_bad++; $display("FAIL rstmid_zero: got %h want 0", {bus.wrt, bus.busy, bus.res_wr,
                              bus.scan_done, bus.err, bus.cmd, bus.res, bus.res_chnl}); end
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
        repeat (20) @(posedge clk); #1;
        n_vec++; if (n_res !== 0 || n_sd !== 0 || n_err !== 0 || n_busy !== 0) begin
            n_bad++; $display("FAIL rstmid_late_done: got res=%0d sd=%0d err=%0d busy=%0d want 0",
                              n_res, n_sd, n_err, n_busy); end
        clear_all();
        start(8'h80, r);
        wait_end(200, to);
        n_vec++; if (to || n_wrt !== 2 || wrt_cmd[0] !== 16'h3800 || wrt_cmd[1] !== 16'h3800) begin
            n_bad++; $display("FAIL rstmid_rescan_cmd: got n=%0d cmd=%h want n=2 cmd=3800", n_wrt, wrt_cmd[0]); end
        n_vec++; if (n_res !== 1 || res_ch[0] !== 3'd7 || res_v[0] !== res_tbl[7] || n_sd !== 1) begin
            n_bad++; $display("FAIL rstmid_rescan_res: got n=%0d ch=%0d res=%h sd=%0d want 1 7 %h 1",
                              n_res, res_ch[0], res_v[0], n_sd, res_tbl[7]); end
    endtask

    task automatic test_timeout();
        int w_at = -1, e_at = -1, nw = 0, nres = 0, nsd = 0;
        logic e_busy = 1'bx;
        @(posedge clk); #1 bus_t.strt = 1'b1; bus_t.chnl_mask = 8'h01;
        @(posedge clk); #1 bus_t.strt = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_t.wrt) begin nw++; if (w_at < 0) w_at = k; end
            if (bus_t.err) begin e_at = k; e_busy = bus_t.busy; end
            if (bus_t.res_wr) nres++;
            if (bus_t.scan_done) nsd++;
        end
        n_vec++; if (nw !== 1 || e_at - w_at !== 17) begin
            n_bad++; $display("FAIL tmo_err_time: got wrt=%0d gap=%0d want 1 17", nw, e_at - w_at); end
        n_vec++; if (e_busy !== 1'b0 || bus_t.busy !== 1'b0) begin
            n_bad++; $display("FAIL tmo_busy: got %b/%b want 0/0", e_busy, bus_t.busy); end
        n_vec++; if (nres !== 0 || nsd !== 0) begin
            n_bad++; $display("FAIL tmo_quiet: got res=%0d sd=%0d want 0 0", nres, nsd); end
    endtask

    task automatic test_timeout_edge();
        int w1 = -1000, w2 = -1000, nw = 0, nerr = 0, nres = 0, nsd = 0;
        @(posedge clk); #1 bus_t.strt = 1'b1; bus_t.chnl_mask = 8'h01;
        @(posedge clk); #1 bus_t.strt = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            bus_t.done = 1'b0;
            if (k == w1 + 16) begin bus_t.done = 1'b1; bus_t.rd_data = 16'h0BAD; end
            if (k == w2 + 1)  begin bus_t.done = 1'b1; bus_t.rd_data = 16'h7123; end
            if (bus_t.wrt) begin nw++; if (nw == 1) w1 = k; else w2 = k; end
            if (bus_t.err) nerr++;
            if (bus_t.res_wr) nres++;
            if (bus_t.scan_done) nsd++;
        end
        n_vec++; if (nw !== 2 || nerr !== 0) begin
            n_bad++; $display("FAIL tmo_edge_no_abort: got wrt=%0d err=%0d want 2 0", nw, nerr); end
        n_vec++; if (nres !== 1 || nsd !== 1 || bus_t.res !== 12'h123 || bus_t.res_chnl !== 3'd0) begin
            n_bad++; $display("FAIL tmo_edge_res: got res_wr=%0d sd=%0d res=%h ch=%0d want 1 1 123 0",
                              nres, nsd, bus_t.res, bus_t.res_chnl); end
    endtask

    initial begin
        res_tbl[0] = 12'hABC; res_tbl[1] = 12'h123; res_tbl[2] = 12'h456; res_tbl[3] = 12'h789;
        res_tbl[4] = 12'h3C5; res_tbl[5] = 12'h5A5; res_tbl[6] = 12'h0F1; res_tbl[7] = 12'hE07;
        bus.strt = 1'b0;   bus.chnl_mask = 8'h00;
        bus_t.strt = 1'b0; bus_t.chnl_mask = 8'h00; bus_t.done = 1'b0; bus_t.rd_data = 16'h0000;
        test_reset();
        test_single();
        test_multi();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_timeout_edge();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
